// File: rtl/number_logger.sv
// Scrolling number console: buffers values/newline tokens in a FIFO and turns
// each one into display commands (POS CLEAR + NUMBER per cell, SCROLL per line).
module number_logger #(
  parameter int DEPTH = 8,
  parameter int COLS  = 13,
  parameter int ROW   = 44
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_value,
  input  logic        in_newline,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  cmd,
  output logic [63:0] data,
  input  logic        disp_ready,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] ROW_Y    = 8'(ROW);
  localparam logic [7:0] COL_LAST = 8'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_CLR, S_WAIT_NUM, S_WAIT_SCR} state_t;

  logic [32:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [7:0]    r_col;
  logic [31:0]   r_value;
  logic [3:0]    r_cmd;
  logic [63:0]   r_data;

  logic          w_push, w_pop, w_go;
  logic [32:0]   w_head;

  // The display's ready is only meaningful while no command is being presented.
  assign w_go     = (r_cmd == 4'd0) & disp_ready;
  assign in_ready = (r_count < (AW+1)'(DEPTH));
  assign w_push   = in_valid & in_ready;
  assign w_pop    = (r_state == S_IDLE) & (r_count != '0) & w_go;
  assign w_head   = r_mem[r_rptr];

  assign cmd  = r_cmd;
  assign data = r_data;
  assign busy = (r_count != '0) | (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_newline, in_value};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd   <= 4'd0;
      r_data  <= 64'd0;
      r_col   <= 8'd0;
      r_value <= 32'd0;
    end else begin
      r_cmd <= 4'd0;
      case (r_state)
        S_IDLE: if (w_pop) begin
          if (w_head[32]) begin
            r_cmd   <= 4'd1;
            r_data  <= 64'd0;
            r_state <= S_WAIT_SCR;
          end else begin
            r_cmd   <= 4'd2;
            r_data  <= {16'd0, r_col, ROW_Y, 32'd0};
            r_value <= w_head[31:0];
            r_state <= S_WAIT_CLR;
          end
        end
        S_WAIT_CLR: if (w_go) begin
          r_cmd   <= 4'd3;
          r_data  <= {16'd0, r_col, ROW_Y, r_value};
          r_state <= S_WAIT_NUM;
        end
        S_WAIT_NUM: if (w_go) begin
          // A full row scrolls immediately so the next value starts a fresh line.
          if (r_col == COL_LAST) begin
            r_col   <= 8'd0;
            r_cmd   <= 4'd1;
            r_data  <= 64'd0;
            r_state <= S_WAIT_SCR;
          end else begin
            r_col   <= r_col + 8'd1;
            r_state <= S_IDLE;
          end
        end
        S_WAIT_SCR: if (w_go) begin
          r_col   <= 8'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
